// File: rtl/fxp_cordic_pkg.sv
// rtl/fxp_cordic_pkg.sv - shared CORDIC state encoding and fixed-point constant helpers
package fxp_cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DRDY = 2'd2
  } cordic_state_t;

  function automatic longint fxp_zero();
    return longint'(0);
  endfunction

  function automatic longint fxp_one(input int point);
    return longint'(1) << point;
  endfunction

  function automatic longint fxp_two(input int point);
    return longint'(2) << point;
  endfunction

  function automatic longint fxp_max(input int width);
    return (longint'(1) << (width - 1)) - longint'(1);
  endfunction

  function automatic longint fxp_min(input int width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/fxp_adder.sv
// rtl/fxp_adder.sv - signed add/subtract with two's complement overflow flag
module fxp_adder #(
  parameter int C_FXP_WIDTH = 16
) (
  input  logic [C_FXP_WIDTH-1:0] A_IN,
  input  logic [C_FXP_WIDTH-1:0] B_IN,
  input  logic                   S_OPE,
  output logic [C_FXP_WIDTH-1:0] S_OUT,
  output logic                   S_OF_FLAG
);

  logic [C_FXP_WIDTH-1:0] w_b;

  // S_OPE=1 subtracts: A + ~B + 1
  always_comb begin
    w_b       = S_OPE ? ~B_IN : B_IN;
    S_OUT     = A_IN + w_b + {{(C_FXP_WIDTH-1){1'b0}}, S_OPE};
    S_OF_FLAG = (A_IN[C_FXP_WIDTH-1] == w_b[C_FXP_WIDTH-1]) &&
                (S_OUT[C_FXP_WIDTH-1] != A_IN[C_FXP_WIDTH-1]);
  end

endmodule

// File: rtl/fxp_cordic_lr.sv
// rtl/fxp_cordic_lr.sv - iterative linear-rotation CORDIC computing Y_IN + X_IN*Z_IN
module fxp_cordic_lr
  import fxp_cordic_pkg::*;
#(
  parameter int C_FXP_WIDTH   = 16,
  parameter int C_FXP_POINT   = 12,
  parameter int C_COR_ITER    = 16,
  parameter int C_MEMPTR_SIZE = $clog2(C_COR_ITER)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  output logic                   BUSY,
  output logic                   DATA_RDY,
  output logic                   OVF,
  input  logic [C_FXP_WIDTH-1:0] X_IN,
  input  logic [C_FXP_WIDTH-1:0] Y_IN,
  input  logic [C_FXP_WIDTH-1:0] Z_IN,
  output logic [C_FXP_WIDTH-1:0] Y_OUT
);

  localparam logic [C_FXP_WIDTH-1:0]   C_ZERO = C_FXP_WIDTH'(fxp_zero());
  localparam logic [C_FXP_WIDTH-1:0]   C_ONE  = C_FXP_WIDTH'(fxp_one(C_FXP_POINT));
  localparam logic [C_FXP_WIDTH-1:0]   C_TWO  = C_FXP_WIDTH'(fxp_two(C_FXP_POINT));
  localparam logic [C_FXP_WIDTH-1:0]   C_MAX  = C_FXP_WIDTH'(fxp_max(C_FXP_WIDTH));
  localparam logic [C_FXP_WIDTH-1:0]   C_MIN  = C_FXP_WIDTH'(fxp_min(C_FXP_WIDTH));
  localparam logic [C_MEMPTR_SIZE-1:0] C_LAST = C_MEMPTR_SIZE'(C_COR_ITER - 1);

  cordic_state_t                   r_state;
  logic signed [C_FXP_WIDTH-1:0]   r_x;
  logic signed [C_FXP_WIDTH-1:0]   r_y;
  logic signed [C_FXP_WIDTH-1:0]   r_z;
  logic        [C_MEMPTR_SIZE-1:0] r_iter;
  logic                            r_sat;
  logic                            r_busy;
  logic                            r_drdy;
  logic                            r_ovf;
  logic        [C_FXP_WIDTH-1:0]   r_yout;

  logic signed [C_FXP_WIDTH-1:0]   w_x_shift;
  logic        [C_FXP_WIDTH-1:0]   w_one_shift;
  logic                            w_neg;
  logic        [C_FXP_WIDTH-1:0]   w_y_sum;
  logic        [C_FXP_WIDTH-1:0]   w_z_sum;
  logic                            w_y_of;
  logic                            w_z_of;
  logic        [C_FXP_WIDTH-1:0]   w_y_next;
  logic                            w_z_range;

  assign w_x_shift   = r_x >>> r_iter;
  assign w_one_shift = C_ONE >> r_iter;
  assign w_neg       = r_z[C_FXP_WIDTH-1];
  assign w_z_range   = ($signed(Z_IN) >= $signed(C_TWO)) || ($signed(Z_IN) <= -$signed(C_TWO));

  // y += d*(x >>> i): d=-1 (subtract) when z is negative
  fxp_adder #(.C_FXP_WIDTH(C_FXP_WIDTH)) u_y_add (
    .A_IN      (r_y),
    .B_IN      (w_x_shift),
    .S_OPE     (w_neg),
    .S_OUT     (w_y_sum),
    .S_OF_FLAG (w_y_of)
  );

  // z -= d*(ONE >> i): drives z toward zero
  fxp_adder #(.C_FXP_WIDTH(C_FXP_WIDTH)) u_z_add (
    .A_IN      (r_z),
    .B_IN      (w_one_shift),
    .S_OPE     (~w_neg),
    .S_OUT     (w_z_sum),
    .S_OF_FLAG (w_z_of)
  );

  // Once y has clipped, later micro-rotations would walk it off the rail by an amount
  // unrelated to the true result, so the clipped value is held for the rest of the operation.
  always_comb begin
    w_y_next = w_y_sum;
    if (r_sat) begin
      w_y_next = r_y;
    end else if (w_y_of) begin
      w_y_next = w_y_sum[C_FXP_WIDTH-1] ? C_MAX : C_MIN;
    end
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_x     <= C_ZERO;
      r_y     <= C_ZERO;
      r_z     <= C_ZERO;
      r_iter  <= '0;
      r_sat   <= 1'b0;
      r_busy  <= 1'b0;
      r_drdy  <= 1'b0;
      r_ovf   <= 1'b0;
      r_yout  <= C_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_drdy <= 1'b0;
          if (START) begin
            r_x     <= X_IN;
            r_y     <= Y_IN;
            r_z     <= Z_IN;
            r_iter  <= '0;
            r_sat   <= 1'b0;
            r_ovf   <= w_z_range;
            r_busy  <= 1'b1;
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_y    <= w_y_next;
          r_z    <= w_z_sum;
          r_iter <= r_iter + C_MEMPTR_SIZE'(1);
          if ((w_y_of && !r_sat) || w_z_of) begin
            r_ovf <= 1'b1;
          end
          if (w_y_of) begin
            r_sat <= 1'b1;
          end
          if (r_iter == C_LAST) begin
            r_yout  <= w_y_next;
            r_busy  <= 1'b0;
            r_drdy  <= 1'b1;
            r_state <= ST_DRDY;
          end
        end
        ST_DRDY: begin
          r_drdy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_drdy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign DATA_RDY = r_drdy;
  assign OVF      = r_ovf;
  assign Y_OUT    = r_yout;

endmodule

// File: tb/tb_fxp_cordic_lr.sv
// tb/tb_fxp_cordic_lr.sv - self-checking bench for fxp_cordic_lr against a multiply-accumulate model
module tb_fxp_cordic_lr;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        BUSY;
  logic        DATA_RDY;
  logic        OVF;
  logic [15:0] X_IN;
  logic [15:0] Y_IN;
  logic [15:0] Z_IN;
  logic [15:0] Y_OUT;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int   lat;
  int   bcnt;
  logic ovf1;
  int   pulses;
  int   q[$];
  int   g1;
  int   g2;
  int   rx;
  int   ry;
  int   rz;

  always #5 CLK = ~CLK;

  fxp_cordic_lr dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .BUSY     (BUSY),
    .DATA_RDY (DATA_RDY),
    .OVF      (OVF),
    .X_IN     (X_IN),
    .Y_IN     (Y_IN),
    .Z_IN     (Z_IN),
    .Y_OUT    (Y_OUT)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: Y + X*Z in Q.12, scaled by 4096 so it stays exact in integers
  task automatic chk_near(input string tag, input logic [15:0] yout, input int x, input int y, input int z);
    int e;
    int d;
    e = y * 4096 + x * z;
    d = int'($signed(yout)) * 4096 - e;
    if (d < 0) d = -d;
    n_chk++;
    assert (d <= 9 * 4096) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d(+-9)", tag, $signed(yout), e / 4096);
    end
  endtask

  // Starts one operation; returns the cycle index of DATA_RDY (cycle 1 follows the START edge),
  // BUSY-high cycles before it, and OVF seen in cycle 1. Leaves the bench in the DRDY cycle.
  task automatic run_op(input int x, input int y, input int z,
                        output int l, output int b, output logic o1);
    @(negedge CLK);
    X_IN  = 16'(x);
    Y_IN  = 16'(y);
    Z_IN  = 16'(z);
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    o1 = OVF;
    l  = 1;
    b  = 0;
    while (!DATA_RDY && l < 40) begin
      b += int'(BUSY);
      @(negedge CLK);
      l++;
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; X_IN = '0; Y_IN = '0; Z_IN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_drdy", int'(DATA_RDY), 0);
    chk("rst_ovf",  int'(OVF), 0);
    chk("rst_yout", int'(Y_OUT), 0);
    RST = 1'b0;

    // basic multiply 1.5 * 0.5
    run_op(6144, 0, 2048, lat, bcnt, ovf1);
    chk("basic_lat", lat, 17);
    chk("basic_busy", bcnt, 16);
    chk("basic_busy_drdy", int'(BUSY), 0);
    chk_near("basic_y", Y_OUT, 6144, 0, 2048);
    chk("basic_ovf", int'(OVF), 0);
    @(negedge CLK);
    chk("basic_drdy_1cyc", int'(DATA_RDY), 0);
    chk_near("basic_y_hold", Y_OUT, 6144, 0, 2048);

    // signs and accumulate
    run_op(-8192, 4096, 3072, lat, bcnt, ovf1);
    chk_near("sign_pos_z", Y_OUT, -8192, 4096, 3072);
    chk("sign_pos_z_ovf", int'(OVF), 0);
    run_op(-8192, 4096, -3072, lat, bcnt, ovf1);
    chk_near("sign_neg_z", Y_OUT, -8192, 4096, -3072);
    chk("sign_neg_z_ovf", int'(OVF), 0);

    // saturation 7.0 * 1.5 exceeds the Q3.12 range
    run_op(28672, 0, 6144, lat, bcnt, ovf1);
    chk("sat_y", int'(Y_OUT), 32767);
    chk("sat_ovf", int'(OVF), 1);
    run_op(4096, 0, 4096, lat, bcnt, ovf1);
    chk("sat_clear_ovf", int'(OVF), 0);
    chk_near("sat_next_y", Y_OUT, 4096, 0, 4096);

    // Z range error: still completes
    run_op(4096, 0, 8192, lat, bcnt, ovf1);
    chk("range_ovf_early", int'(ovf1), 1);
    chk("range_lat", lat, 17);
    chk("range_ovf_drdy", int'(OVF), 1);

    // START re-pulsed during ITER and held through DRDY: one result only
    @(negedge CLK);
    X_IN = 16'd4096; Y_IN = 16'd0; Z_IN = 16'd2048; START = 1'b1;
    @(posedge CLK);
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge CLK);
      START = (c == 5) || (c >= 14 && c <= 17);
      pulses += int'(DATA_RDY);
    end
    chk("hs_one_pulse", pulses, 1);
    chk("hs_idle_busy", int'(BUSY), 0);

    // START held continuously: results every 18 cycles
    @(negedge CLK);
    X_IN = 16'd4096; Y_IN = 16'd0; Z_IN = 16'd2048; START = 1'b1;
    @(posedge CLK);
    q.delete();
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (DATA_RDY) q.push_back(c);
    end
    START = 1'b0;
    g1 = (q.size() >= 2) ? q[1] - q[0] : -1;
    g2 = (q.size() >= 3) ? q[2] - q[1] : -1;
    chk("cont_count", q.size(), 3);
    chk("cont_gap1", g1, 18);
    chk("cont_gap2", g2, 18);
    repeat (20) @(negedge CLK);
    chk_near("cont_y", Y_OUT, 4096, 0, 2048);

    // reset at iteration 7 of an operation with OVF set
    @(negedge CLK);
    X_IN = 16'd4096; Y_IN = 16'd0; Z_IN = 16'd8192; START = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    chk("mid_pre_ovf", int'(OVF), 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_busy", int'(BUSY), 0);
    chk("mid_yout", int'(Y_OUT), 0);
    chk("mid_ovf", int'(OVF), 0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      pulses += int'(DATA_RDY);
    end
    chk("mid_no_drdy", pulses, 0);
    run_op(6144, 1024, -2048, lat, bcnt, ovf1);
    chk("mid_after_lat", lat, 17);
    chk_near("mid_after_y", Y_OUT, 6144, 1024, -2048);

    // randomized in-range operations
    for (int k = 0; k < 8; k++) begin
      rx = 512 * (int'($urandom_range(14)) - 7);
      ry = int'($urandom_range(16383)) - 8192;
      rz = int'($urandom_range(16382)) - 8191;
      run_op(rx, ry, rz, lat, bcnt, ovf1);
      chk("rand_lat", lat, 17);
      chk_near("rand_y", Y_OUT, rx, ry, rz);
      chk("rand_ovf", int'(OVF), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
